// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXECUTE/MEM/WB sequencer for a multi-cycle RV32I datapath.
// Ports: clk/rst_n (async active-low); instr, imem_ready, dmem_ready, br_taken in;
// imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, imme_sel, wb_sel, alu_op, trap, trap_cause out.
module multicycle_ctrl #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [2:0]  imme_sel,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_op,
    output logic        trap,
    output logic [1:0]  trap_cause
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    state_t state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d, cnt_sat;
    logic [6:0] opc_q, opc_d;
    logic [2:0] f3_q, f3_d, sel_q, sel_d, dec_sel;
    logic [1:0] alu_q, alu_d, cause_q, cause_d, dec_alu;
    logic dec_ok, is_load, is_store, is_branch, is_jump, timeout;
    logic unused_bits;
    assign is_load   = opc_q == 7'b0000011;
    assign is_store  = opc_q == 7'b0100011;
    assign is_branch = opc_q == 7'b1100011;
    assign is_jump   = opc_q == 7'b1101111 || opc_q == 7'b1100111;
    assign cnt_sat   = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign timeout   = cnt_sat == WAIT_W'(MAX_WAIT);
    // funct3 is latched for the datapath's benefit; this controller does not consume it.
    assign unused_bits = ^{instr[31:15], instr[11:7], f3_q, br_taken};
    always_comb begin
        dec_ok  = 1'b1;
        dec_sel = 3'b000;
        dec_alu = 2'b00;
        case (opc_q)
            7'b0110011: dec_alu = 2'b10;
            7'b0010011: {dec_sel, dec_alu} = {3'b001, 2'b10};
            7'b0000011,
            7'b1100111: dec_sel = 3'b001;
            7'b0100011: dec_sel = 3'b011;
            7'b1100011: {dec_sel, dec_alu} = {3'b010, 2'b01};
            7'b0110111,
            7'b0010111: dec_sel = 3'b100;
            7'b1101111: dec_sel = 3'b101;
            default:    dec_ok = 1'b0;
        endcase
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opc_d   = opc_q;
        f3_d    = f3_q;
        sel_d   = sel_q;
        alu_d   = alu_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    opc_d   = instr[6:0];
                    f3_d    = instr[14:12];
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            S_DECODE: begin
                state_d = dec_ok ? S_EXEC : S_TRAP;
                cause_d = dec_ok ? cause_q : 2'b01;
                sel_d   = dec_sel;
                alu_d   = dec_alu;
            end
            S_EXEC: state_d = is_branch ? S_FETCH : (is_load || is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = is_load ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_TRAP;
        endcase
        // Every state change restarts the timeout window.
        if (state_d != state_q) cnt_d = '0;
        if (state_d == S_FETCH || state_d == S_TRAP) {sel_d, alu_d} = '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            opc_q   <= '0;
            f3_q    <= '0;
            sel_q   <= '0;
            alu_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
            f3_q    <= f3_d;
            sel_q   <= sel_d;
            alu_q   <= alu_d;
            cause_q <= cause_d;
        end
    end
    // Outputs are gated by rst_n so nothing fires while reset is held.
    assign imem_req   = rst_n && state_q == S_FETCH;
    assign ir_we      = imem_req && imem_ready;
    assign dmem_req   = rst_n && state_q == S_MEM;
    assign dmem_we    = dmem_req && is_store;
    assign reg_we     = rst_n && state_q == S_WB;
    assign pc_we      = rst_n && ((state_q == S_EXEC && is_branch) ||
                                  (state_q == S_MEM && is_store && dmem_ready) || state_q == S_WB);
    assign wb_sel     = !reg_we ? 2'b00 : is_load ? 2'b01 : is_jump ? 2'b10 : 2'b00;
    assign imme_sel   = sel_q;
    assign alu_op     = alu_q;
    assign trap       = state_q == S_TRAP;
    assign trap_cause = cause_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl using a per-instruction output-sequence model.
module tb_multicycle_ctrl;
    localparam int MAX_WAIT = 15;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0, br_taken = 1'b0;
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, trap;
    logic [2:0] imme_sel;
    logic [1:0] wb_sel, alu_op, trap_cause;

    multicycle_ctrl #(.WAIT_W(4), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .imme_sel(imme_sel), .wb_sel(wb_sel), .alu_op(alu_op),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
        logic [2:0] imme_sel;
        logic [1:0] wb_sel, alu_op;
        logic trap;
        logic [1:0] trap_cause;
    } ov_t;

    typedef struct packed {
        logic [31:0] ins;
        logic ir, dr, bt;
        ov_t o;
    } step_t;

    step_t sq[$];
    ov_t got, exp_o;
    bit chk = 1'b0;
    string tag = "init";
    int total = 0, bad = 0;

    assign got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we,
                  imme_sel, wb_sel, alu_op, trap, trap_cause};

    always @(negedge clk) begin
        if (chk) begin
            total++;
            if (got !== exp_o) begin
                bad++;
                $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp_o);
            end
        end
    end

    task automatic lit(input string nm, input int g, input int e);
        total++;
        if (g != e) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, g, e);
        end
    endtask

    // kind: 0 plain, 1 load, 2 store, 3 branch
    task automatic classify(input logic [6:0] op, output bit ok, output logic [2:0] sel,
                            output logic [1:0] alu, output logic [1:0] wb, output int kind);
        ok = 1'b1; sel = 3'd0; alu = 2'd0; wb = 2'd0; kind = 0;
        case (op)
            7'b0110011: alu = 2'd2;
            7'b0010011: begin sel = 3'd1; alu = 2'd2; end
            7'b0000011: begin sel = 3'd1; wb = 2'd1; kind = 1; end
            7'b1100111: begin sel = 3'd1; wb = 2'd2; end
            7'b0100011: begin sel = 3'd3; kind = 2; end
            7'b1100011: begin sel = 3'd2; alu = 2'd1; kind = 3; end
            7'b0110111, 7'b0010111: sel = 3'd4;
            7'b1101111: begin sel = 3'd5; wb = 2'd2; end
            default: ok = 1'b0;
        endcase
    endtask

    function automatic step_t mk(input logic [31:0] ins, input logic ir, input logic dr,
                                 input logic bt, input ov_t o);
        step_t s;
        s.ins = ins; s.ir = ir; s.dr = dr; s.bt = bt; s.o = o;
        return s;
    endfunction

    task automatic push_trap(input logic [1:0] c);
        ov_t o;
        for (int i = 0; i < 3; i++) begin
            o = '0; o.trap = 1'b1; o.trap_cause = c;
            sq.push_back(mk(32'h0, 1'b1, 1'b1, 1'b1, o));
        end
    endtask

    // Expected cycle-by-cycle outputs for one instruction: iw unacked fetch cycles,
    // dw unacked memory cycles; readies outside their phase are driven as noise.
    task automatic build(input logic [31:0] ins, input int iw, input int dw, input bit bt);
        bit ok; logic [2:0] sel; logic [1:0] alu, wb; int kind; ov_t o;
        classify(ins[6:0], ok, sel, alu, wb, kind);
        sq.delete();
        for (int i = 0; i < iw && i < MAX_WAIT; i++) begin
            o = '0; o.imem_req = 1'b1;
            sq.push_back(mk(ins, 1'b0, 1'b1, 1'b0, o));
        end
        if (iw >= MAX_WAIT) begin push_trap(2'd2); return; end
        o = '0; o.imem_req = 1'b1; o.ir_we = 1'b1;
        sq.push_back(mk(ins, 1'b1, 1'b0, 1'b0, o));
        sq.push_back(mk(32'h0, 1'b1, 1'b1, 1'b0, '0));
        if (!ok) begin push_trap(2'd1); return; end
        o = '0; o.imme_sel = sel; o.alu_op = alu; o.pc_we = (kind == 3);
        sq.push_back(mk(32'h0, 1'b1, 1'b1, bt, o));
        if (kind == 3) return;
        if (kind == 1 || kind == 2) begin
            o.dmem_req = 1'b1; o.dmem_we = (kind == 2);
            for (int i = 0; i < dw; i++) sq.push_back(mk(32'h0, 1'b1, 1'b0, 1'b0, o));
            o.pc_we = (kind == 2);
            sq.push_back(mk(32'h0, 1'b1, 1'b1, 1'b0, o));
            if (kind == 2) return;
        end
        o.dmem_req = 1'b0; o.dmem_we = 1'b0; o.reg_we = 1'b1; o.pc_we = 1'b1; o.wb_sel = wb;
        sq.push_back(mk(32'h0, 1'b1, 1'b1, 1'b0, o));
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n && i < sq.size(); i++) begin
            instr = sq[i].ins; imem_ready = sq[i].ir; dmem_ready = sq[i].dr;
            br_taken = sq[i].bt; exp_o = sq[i].o; chk = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input string t, input logic [31:0] ins, input int iw, input int dw, input bit bt);
        tag = t;
        build(ins, iw, dw, bt);
        play(sq.size());
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        lit({tag, "_async_clr"}, int'(got), 0);
        exp_o = '0; chk = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // model pins
        build(32'h002081B3, 0, 0, 1'b0);
        lit("pin_add_len", sq.size(), 4);
        lit("pin_add_regwe", int'(sq[3].o.reg_we), 1);
        lit("pin_add_alu", int'(sq[2].o.alu_op), 2);
        build(32'h0000A103, 2, 3, 1'b0);
        lit("pin_lw_len", sq.size(), 10);
        lit("pin_lw_wbsel", int'(sq[9].o.wb_sel), 1);
        build(32'h0020A223, 0, 1, 1'b0);
        lit("pin_sw_len", sq.size(), 5);
        lit("pin_sw_pcwe", int'(sq[4].o.pc_we), 1);
        build(32'h00208463, 0, 0, 1'b1);
        lit("pin_beq_len", sq.size(), 3);
        lit("pin_beq_sel", int'(sq[2].o.imme_sel), 2);
        build(32'h0000007F, 0, 0, 1'b0);
        lit("pin_ill_cause", int'(sq[2].o.trap_cause), 1);
        build(32'h002081B3, 15, 0, 1'b0);
        lit("pin_to_len", sq.size(), 18);
        lit("pin_to_cause", int'(sq[15].o.trap_cause), 2);

        @(posedge clk); #1;
        tag = "reset";
        reset_pulse();
        run("add", 32'h002081B3, 0, 0, 1'b0);
        run("lw", 32'h0000A103, 2, 3, 1'b0);
        run("sw", 32'h0020A223, 0, 1, 1'b0);
        run("beq_t", 32'h00208463, 0, 0, 1'b1);
        run("beq_nt", 32'h00208463, 1, 0, 1'b0);
        run("addi", 32'h00108093, 0, 0, 1'b0);
        run("lui", 32'h123450B7, 0, 0, 1'b0);
        run("auipc", 32'h00000097, 0, 0, 1'b0);
        run("jal", 32'h008000EF, 0, 0, 1'b0);
        run("jalr", 32'h000080E7, 3, 0, 1'b0);
        run("add_w14", 32'h002081B3, 14, 0, 1'b0);
        run("sw_d0", 32'h0020A223, 0, 0, 1'b0);
        run("lw_d0", 32'h0000A103, 0, 0, 1'b0);

        tag = "midload";
        build(32'h0000A103, 0, 5, 1'b0);
        play(5);
        lit("midload_req", int'(dmem_req), 1);
        reset_pulse();
        run("add_after_rst", 32'h002081B3, 0, 0, 1'b0);

        run("illegal", 32'h0000007F, 0, 0, 1'b0);
        reset_pulse();
        run("add_after_ill", 32'h002081B3, 0, 0, 1'b0);

        run("fetch_timeout", 32'h002081B3, 15, 0, 1'b0);
        reset_pulse();
        run("beq_after_to", 32'h00208463, 0, 0, 1'b1);

        chk = 1'b0;
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
FSM controller that converts the single-cycle RV32I datapath into a multi-cycle one, so the ALU, the operand-B select and the shared memory port are reused across cycles.
Sequences FETCH/DECODE/EXECUTE/MEM/WB and drives the operand-B select code (imme_sel) plus all write enables.
Handshakes with the instruction and data memories.
Sits between the fetch unit / instruction register and the datapath mux, ALU and register file.

Parameters:
WAIT_W, 4, width of the memory-wait timeout counter
MAX_WAIT, 15, cycles a memory request may stay unacknowledged before a bus-error trap (must be < 2^WAIT_W)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr  input  32  instruction word from imem, sampled when imem_ready=1 in FETCH
imem_ready  input  1  instruction memory acknowledge
dmem_ready  input  1  data memory acknowledge
br_taken  input  1  branch comparator result, valid in EXECUTE
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (store)
ir_we  output  1  instruction register load pulse
pc_we  output  1  PC update pulse
reg_we  output  1  register file write pulse
imme_sel  output  3  operand-B select: 000 rs2, 001 I, 010 B, 011 S, 100 U, 101 UJ
wb_sel  output  2  write-back source: 00 ALU, 01 load data, 10 PC+4
alu_op  output  2  00 add, 01 compare (branch), 10 funct3/funct7 decoded
trap  output  1  sticky fault indicator
trap_cause  output  2  01 illegal opcode, 10 bus timeout

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH.
  - All outputs 0, except imem_req, which is 1 once reset is released (FETCH asserts it combinationally).
  - Wait counter = 0. Latched opcode = 0.
  - Reset mid-operation aborts immediately; no write pulse may fire in the reset cycle.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_we=1 for that cycle, latch instr[6:0] and instr[14:12], go to DECODE.
  - Otherwise increment the wait counter. When the counter reaches MAX_WAIT → TRAP, cause 10.
- DECODE (1 cycle): classify the latched opcode.
  - 0110011 R → 000, alu 10
  - 0010011 I-ALU → 001, alu 10
  - 0000011 LOAD → 001, alu 00
  - 1100111 JALR → 001, alu 00
  - 0100011 STORE → 011, alu 00
  - 1100011 BRANCH → 010, alu 01
  - 0110111 LUI / 0010111 AUIPC → 100, alu 00
  - 1101111 JAL → 101, alu 00
  - Any other opcode → TRAP, cause 01.
  - Otherwise → EXECUTE.
- imme_sel and alu_op:
  - Driven from a registered copy set in DECODE.
  - Stable through EXECUTE, MEM and WB.
  - 000 and 00 in FETCH and TRAP.
- EXECUTE (1 cycle):
  - BRANCH: pc_we=br_taken (target PC); → FETCH. If not taken, the PC+4 update is the pc_we pulse in this same cycle.
  - LOAD/STORE → MEM.
  - All others → WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE only.
  - Wait counter is reset to 0 on entry.
  - On dmem_ready: LOAD → WB; STORE → pc_we=1, → FETCH.
  - Timeout at MAX_WAIT → TRAP, cause 10.
- WB (1 cycle):
  - reg_we=1 and pc_we=1; → FETCH.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - JAL/JALR: the PC takes the jump target; ALU result with imme_sel 101 (JAL) or 001 (JALR).
- TRAP:
  - Absorbing state. trap=1, trap_cause held.
  - All request and write outputs 0.
  - Exit only via reset.
- Write pulses: ir_we, pc_we and reg_we are single-cycle pulses, never asserted in two consecutive cycles.
- Ready signals: a ready that arrives in the same cycle as req asserts counts; a ready without req is ignored.
- Wait counter: saturating; cleared on every state change.
- Minimum latencies (ready in the first cycle):
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH: 3 cycles

Test Plan:
- R-type ADD 0x002081B3, imem_ready immediate → imem_req c0; ir_we c0; DECODE c1; EXECUTE c2 with imme_sel=000, alu_op=10; WB c3 with reg_we=1, pc_we=1, wb_sel=00; FETCH c4.
- LW 0x0000A103, dmem_ready delayed 3 cycles → imme_sel=001; dmem_req high 4 cycles with dmem_we=0; then WB with wb_sel=01, reg_we=1.
- SW 0x0020A223 → imme_sel=011; dmem_we=1 in MEM; pc_we on dmem_ready; reg_we never asserted.
- BEQ with br_taken=1, then a second BEQ with br_taken=0 → imme_sel=010, alu_op=01; pc_we=1 in EXECUTE both times; back in FETCH after 3 cycles; reg_we=0.
- Opcode 0x7F (0000000_..._1111111) → trap=1 and trap_cause=01 in the cycle after DECODE; all pulses 0; trap held until rst_n=0.
- imem_ready held 0 for MAX_WAIT=15 cycles → TRAP, cause 10. Then rst_n pulled low mid-LOAD on a later run → outputs clear asynchronously; FETCH resumes after release.
